wb_retire_unit: RTL and testbench
=================================

Name: wb_retire_unit

Overview:
Parametrised write-back/retire stage that replaces the single-register WB stage with a QDEPTH-entry in-order retire queue.
- Accepts instructions from MEM over a valid/allowin handshake.
- Retires one entry per cycle unless the trace/debug side asserts retire_stall.
- Resolves multiple exception flags by fixed priority and raises flush for exceptions and ertn.
- Provides CSR-hazard status and a 64-bit retired-instruction counter.

Parameters:
- DATA_W, 32, width of PC, result and CSR data.
- RF_AW, 5, GPR address width.
- QDEPTH, 2, retire-queue entries; power of two, minimum 2.
- EXC_NUM, 6, number of exception-flag bits.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ms_to_ws_valid  in  1  MEM has an instruction
- ws_allowin  out  1  queue can accept this cycle
- ms_pc  in  DATA_W  instruction PC
- ms_gr_we  in  1  GPR write enable
- ms_dest  in  RF_AW  GPR destination
- ms_result  in  DATA_W  GPR write data
- ms_csr_we  in  1  CSR write enable
- ms_csr_wnum  in  14  CSR number
- ms_csr_wmask  in  DATA_W  CSR write mask
- ms_csr_wdata  in  DATA_W  CSR write data
- ms_ertn  in  1  instruction is ertn
- ms_exc_flgs  in  EXC_NUM  exception flags, bit indices from the package
- retire_stall  in  1  hold the head entry (trace back-pressure)
- rf_we / rf_waddr / rf_wdata  out  1 / RF_AW / DATA_W  GPR write port
- debug_wb_pc / debug_wb_rf_wen / debug_wb_rf_wnum / debug_wb_rf_wdata  out  DATA_W / 4 / RF_AW / DATA_W  trace
- csr_we / csr_wnum / csr_wmask / csr_wval  out  1 / 14 / DATA_W / DATA_W  CSR write port
- wb_exc  out  1  exception commit pulse
- wb_ecode  out  6  exception code
- wb_esubcode  out  9  exception subcode
- wb_pc  out  DATA_W  PC of the committing entry
- ertn_flush  out  1  ertn commit pulse
- csr_pending  out  1  any valid entry has csr_we or ertn
- csr_pending_wnum  out  14  csr_wnum of the youngest valid csr_we entry (0 if none)
- q_count  out  clog2(QDEPTH)+1  occupancy
- instret  out  64  retired-instruction counter

Behaviour:
- Reset:
  - Clock is clk; reset is synchronous, active-high.
  - Clears head/tail pointers, count, all entry valid bits and instret.
  - All outputs read 0 after reset; ws_allowin is 1.
- Queue:
  - Circular buffer; head and tail wrap modulo QDEPTH.
  - Push when ms_to_ws_valid && ws_allowin; the entry is written at tail, tail increments.
  - ws_allowin = (count != QDEPTH) && !flush. It is computed from registered count only; no same-cycle pop bypass.
- Commit:
  - commit = head valid && !retire_stall. Latency is 1 cycle minimum from push to commit.
  - Normal commit:
    - rf_we = head.gr_we; csr_we = head.csr_we; head pops.
    - instret increments by 1.
  - Exception commit (|head.exc_flgs):
    - wb_exc = 1 for one cycle; wb_pc = head.pc.
    - rf_we = 0 and csr_we = 0; instret does not increment.
  - ertn commit without exception: ertn_flush = 1 for one cycle; instret increments.
- Flush:
  - flush = wb_exc | ertn_flush.
  - Clears every entry, count and pointers at the next edge.
  - A push presented in the flush cycle is dropped, because ws_allowin = 0.
- Exception priority (highest first): INT, ADEF, INE, SYS, BRK, ALE. Only the winner drives wb_ecode.
  - wb_esubcode = ESUBCODE_ADEF when ADEF wins, else 0.
  - wb_ecode and wb_esubcode are 0 when wb_exc = 0.
- Trace:
  - debug_wb_pc = head.pc; debug_wb_rf_wnum = head.dest; debug_wb_rf_wdata = head.result.
  - debug_wb_rf_wen = {4{rf_we}}, which is 0 while stalled.
- Count:
  - Push and pop in the same cycle leave count unchanged.
  - Push while full cannot occur.
- instret wraps at 2^64 − 1 → 0.
- Reset mid-operation discards queue contents without any wb_exc or ertn_flush pulse.

Decomposition:
- Shared package (existing csr header): EXC_FLG_* indices, ECODE_*, ESUBCODE_ADEF, the EXC_NUM default, and the retire-entry struct/bus width.
- Natural sub-module: wb_exc_prio, a combinational priority encoder mapping flags to ecode/esubcode, reusable by other stages.

Test Plan:
- Push 3 back-to-back entries (QDEPTH=2) with retire_stall=0 → one rf_we per cycle in order; ws_allowin never 0; instret=3.
- retire_stall=1 for 4 cycles while pushing → q_count=2, ws_allowin=0, rf_we=0. Release stall → the 2 entries retire in consecutive cycles.
- Head with SYS|BRK flags, pc=0x1c000040 → wb_exc=1, wb_ecode=ECODE_SYS, wb_pc=0x1c000040, rf_we=0; queue empty next cycle; younger entry dropped.
- Head with ADEF|INT → ecode=ECODE_INT, esubcode=0. ADEF only → ecode=ECODE_ADE, esubcode=ESUBCODE_ADEF.
- ertn at head, csr_we entry behind it → csr_pending=1 before commit; ertn_flush pulses 1 cycle; younger csr write never reaches csr_we.
- Assert reset with 2 entries queued → q_count=0, ws_allowin=1, no wb_exc or ertn_flush, instret=0.

Source files
------------

// File: rtl/wb_retire_unit_pkg.sv
//==============================================================================
// Module      : wb_retire_unit_pkg
// Description : Exception-flag indices, exception codes and retire-entry
//               bus width shared by the write-back/retire stage.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package wb_retire_unit_pkg;

    localparam int EXC_NUM_DEF = 6;
    localparam int CSR_NUM_W   = 14;

    // Flag bit positions, listed in descending commit priority
    localparam int EXC_FLG_INT  = 0;
    localparam int EXC_FLG_ADEF = 1;
    localparam int EXC_FLG_INE  = 2;
    localparam int EXC_FLG_SYS  = 3;
    localparam int EXC_FLG_BRK  = 4;
    localparam int EXC_FLG_ALE  = 5;

    localparam logic [5:0] ECODE_INT = 6'h00;
    localparam logic [5:0] ECODE_ADE = 6'h08;
    localparam logic [5:0] ECODE_ALE = 6'h09;
    localparam logic [5:0] ECODE_SYS = 6'h0b;
    localparam logic [5:0] ECODE_BRK = 6'h0c;
    localparam logic [5:0] ECODE_INE = 6'h0d;

    localparam logic [8:0] ESUBCODE_ADEF = 9'h000;

    // Entry layout, MSB first: pc, gr_we, dest, result, csr_we, csr_wnum,
    // csr_wmask, csr_wdata, ertn, exc_flgs
    function automatic int retire_entry_w(input int data_w, input int rf_aw,
                                          input int exc_num);
        return 4 * data_w + rf_aw + exc_num + CSR_NUM_W + 3;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_exc_prio.sv
//==============================================================================
// Module      : wb_exc_prio
// Description : Fixed-priority encoder from exception flags to ecode/esubcode.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module wb_exc_prio
    import wb_retire_unit_pkg::*;
#(
    parameter int EXC_NUM = EXC_NUM_DEF
) (
    input  logic [EXC_NUM-1:0] exc_flgs,
    output logic [5:0]         ecode,
    output logic [8:0]         esubcode
);

    always_comb begin
        ecode    = '0;
        esubcode = '0;
        if (exc_flgs[EXC_FLG_INT]) begin
            ecode = ECODE_INT;
        end else if (exc_flgs[EXC_FLG_ADEF]) begin
            ecode    = ECODE_ADE;
            esubcode = ESUBCODE_ADEF;
        end else if (exc_flgs[EXC_FLG_INE]) begin
            ecode = ECODE_INE;
        end else if (exc_flgs[EXC_FLG_SYS]) begin
            ecode = ECODE_SYS;
        end else if (exc_flgs[EXC_FLG_BRK]) begin
            ecode = ECODE_BRK;
        end else if (exc_flgs[EXC_FLG_ALE]) begin
            ecode = ECODE_ALE;
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_retire_unit.sv
//==============================================================================
// Module      : wb_retire_unit
// Description : In-order retire queue for the write-back stage with exception
//               resolution, flush generation, CSR hazard status and instret.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module wb_retire_unit
    import wb_retire_unit_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RF_AW   = 5,
    parameter int QDEPTH  = 2,
    parameter int EXC_NUM = EXC_NUM_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ms_to_ws_valid,
    output logic                      ws_allowin,
    input  logic [DATA_W-1:0]         ms_pc,
    input  logic                      ms_gr_we,
    input  logic [RF_AW-1:0]          ms_dest,
    input  logic [DATA_W-1:0]         ms_result,
    input  logic                      ms_csr_we,
    input  logic [13:0]               ms_csr_wnum,
    input  logic [DATA_W-1:0]         ms_csr_wmask,
    input  logic [DATA_W-1:0]         ms_csr_wdata,
    input  logic                      ms_ertn,
    input  logic [EXC_NUM-1:0]        ms_exc_flgs,
    input  logic                      retire_stall,
    output logic                      rf_we,
    output logic [RF_AW-1:0]          rf_waddr,
    output logic [DATA_W-1:0]         rf_wdata,
    output logic [DATA_W-1:0]         debug_wb_pc,
    output logic [3:0]                debug_wb_rf_wen,
    output logic [RF_AW-1:0]          debug_wb_rf_wnum,
    output logic [DATA_W-1:0]         debug_wb_rf_wdata,
    output logic                      csr_we,
    output logic [13:0]               csr_wnum,
    output logic [DATA_W-1:0]         csr_wmask,
    output logic [DATA_W-1:0]         csr_wval,
    output logic                      wb_exc,
    output logic [5:0]                wb_ecode,
    output logic [8:0]                wb_esubcode,
    output logic [DATA_W-1:0]         wb_pc,
    output logic                      ertn_flush,
    output logic                      csr_pending,
    output logic [13:0]               csr_pending_wnum,
    output logic [$clog2(QDEPTH):0]   q_count,
    output logic [63:0]               instret
);

    localparam int PTR_W   = $clog2(QDEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = retire_entry_w(DATA_W, RF_AW, EXC_NUM);
    localparam int ERTN_B  = EXC_NUM;
    localparam int CWN_LO  = EXC_NUM + 1 + 2 * DATA_W;
    localparam int CWE_B   = CWN_LO + CSR_NUM_W;

    logic [ENTRY_W-1:0] entry_q [QDEPTH];
    logic [ENTRY_W-1:0] entry_d [QDEPTH];
    logic [QDEPTH-1:0]  valid_q, valid_d;
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [63:0]        instret_q, instret_d;

    logic [DATA_W-1:0]  h_pc, h_result, h_cwmask, h_cwdata;
    logic               h_gr_we, h_csr_we, h_ertn;
    logic [RF_AW-1:0]   h_dest;
    logic [13:0]        h_cwnum;
    logic [EXC_NUM-1:0] h_exc;
    logic               head_valid, commit, has_exc, ok_commit, flush, push;
    logic [5:0]         prio_ecode;
    logic [8:0]         prio_esubcode;
    logic [PTR_W-1:0]   scan_idx;

    assign {h_pc, h_gr_we, h_dest, h_result, h_csr_we, h_cwnum,
            h_cwmask, h_cwdata, h_ertn, h_exc} = entry_q[head_q];

    assign head_valid = valid_q[head_q];
    assign commit     = head_valid && !retire_stall;
    assign has_exc    = |h_exc;
    assign ok_commit  = commit && !has_exc;
    assign flush      = wb_exc || ertn_flush;
    // Occupancy comes from the registered count only; a pop this cycle does not free a slot
    assign ws_allowin = (count_q != CNT_W'(QDEPTH)) && !flush;
    assign push       = ms_to_ws_valid && ws_allowin;

    assign wb_exc      = commit && has_exc;
    assign ertn_flush  = ok_commit && h_ertn;
    assign wb_ecode    = wb_exc ? prio_ecode : 6'd0;
    assign wb_esubcode = wb_exc ? prio_esubcode : 9'd0;
    assign wb_pc       = head_valid ? h_pc : '0;

    assign rf_we    = ok_commit && h_gr_we;
    assign rf_waddr = head_valid ? h_dest : '0;
    assign rf_wdata = head_valid ? h_result : '0;

    assign csr_we    = ok_commit && h_csr_we;
    assign csr_wnum  = head_valid ? h_cwnum : '0;
    assign csr_wmask = head_valid ? h_cwmask : '0;
    assign csr_wval  = head_valid ? h_cwdata : '0;

    assign debug_wb_pc       = head_valid ? h_pc : '0;
    assign debug_wb_rf_wen   = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

    assign q_count = count_q;
    assign instret = instret_q;

    wb_exc_prio #(
        .EXC_NUM (EXC_NUM)
    ) u_exc_prio (
        .exc_flgs (h_exc),
        .ecode    (prio_ecode),
        .esubcode (prio_esubcode)
    );

    // Walk oldest to youngest so the youngest csr_we entry sets the number
    always_comb begin
        csr_pending      = 1'b0;
        csr_pending_wnum = '0;
        scan_idx         = head_q;
        for (int i = 0; i < QDEPTH; i++) begin
            scan_idx = head_q + PTR_W'(i);
            if (valid_q[scan_idx] &&
                (entry_q[scan_idx][CWE_B] || entry_q[scan_idx][ERTN_B])) begin
                csr_pending = 1'b1;
            end
            if (valid_q[scan_idx] && entry_q[scan_idx][CWE_B]) begin
                csr_pending_wnum = entry_q[scan_idx][CWN_LO +: CSR_NUM_W];
            end
        end
    end

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        valid_d   = valid_q;
        entry_d   = entry_q;
        instret_d = instret_q;
        if (ok_commit) begin
            instret_d = instret_q + 64'd1;
        end
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            valid_d = '0;
        end else begin
            if (push) begin
                entry_d[tail_q] = {ms_pc, ms_gr_we, ms_dest, ms_result, ms_csr_we,
                                   ms_csr_wnum, ms_csr_wmask, ms_csr_wdata,
                                   ms_ertn, ms_exc_flgs};
                valid_d[tail_q] = 1'b1;
                tail_d          = tail_q + PTR_W'(1);
            end
            if (commit) begin
                valid_d[head_q] = 1'b0;
                head_d          = head_q + PTR_W'(1);
            end
            case ({push, commit})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            valid_q   <= '0;
            instret_q <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            instret_q <= instret_d;
        end
    end

    // Payload needs no reset: every consumer is gated by the entry valid bit
    always_ff @(posedge clk) begin
        entry_q <= entry_d;
    end

endmodule

`default_nettype wire

// File: tb/tb_wb_retire_unit.sv
//==============================================================================
// Module      : tb_wb_retire_unit
// Description : Directed self-checking bench for wb_retire_unit (QDEPTH=2).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_wb_retire_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ms_to_ws_valid;
    logic [31:0] ms_pc;
    logic        ms_gr_we;
    logic [4:0]  ms_dest;
    logic [31:0] ms_result;
    logic        ms_csr_we;
    logic [13:0] ms_csr_wnum;
    logic [31:0] ms_csr_wmask;
    logic [31:0] ms_csr_wdata;
    logic        ms_ertn;
    logic [5:0]  ms_exc_flgs;
    logic        retire_stall;

    logic        ws_allowin, rf_we, csr_we, wb_exc, ertn_flush, csr_pending;
    logic [4:0]  rf_waddr, debug_wb_rf_wnum;
    logic [31:0] rf_wdata, debug_wb_pc, debug_wb_rf_wdata, csr_wmask, csr_wval, wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [13:0] csr_wnum, csr_pending_wnum;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [1:0]  q_count;
    logic [63:0] instret;

    int n_checks = 0;
    int n_fail   = 0;

    wb_retire_unit #(
        .DATA_W  (32),
        .RF_AW   (5),
        .QDEPTH  (2),
        .EXC_NUM (6)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ws_allowin        (ws_allowin),
        .ms_pc             (ms_pc),
        .ms_gr_we          (ms_gr_we),
        .ms_dest           (ms_dest),
        .ms_result         (ms_result),
        .ms_csr_we         (ms_csr_we),
        .ms_csr_wnum       (ms_csr_wnum),
        .ms_csr_wmask      (ms_csr_wmask),
        .ms_csr_wdata      (ms_csr_wdata),
        .ms_ertn           (ms_ertn),
        .ms_exc_flgs       (ms_exc_flgs),
        .retire_stall      (retire_stall),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata),
        .csr_we            (csr_we),
        .csr_wnum          (csr_wnum),
        .csr_wmask         (csr_wmask),
        .csr_wval          (csr_wval),
        .wb_exc            (wb_exc),
        .wb_ecode          (wb_ecode),
        .wb_esubcode       (wb_esubcode),
        .wb_pc             (wb_pc),
        .ertn_flush        (ertn_flush),
        .csr_pending       (csr_pending),
        .csr_pending_wnum  (csr_pending_wnum),
        .q_count           (q_count),
        .instret           (instret)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic gwe,
                         input logic [4:0] dst, input logic [31:0] res, input logic cwe,
                         input logic [13:0] cn, input logic ert, input logic [5:0] exc);
        ms_to_ws_valid = v;
        ms_pc          = pc;
        ms_gr_we       = gwe;
        ms_dest        = dst;
        ms_result      = res;
        ms_csr_we      = cwe;
        ms_csr_wnum    = cn;
        ms_csr_wmask   = ~res;
        ms_csr_wdata   = res;
        ms_ertn        = ert;
        ms_exc_flgs    = exc;
    endtask

    task automatic idle;
        drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 14'h0, 1'b0, 6'h0);
    endtask

    initial begin
        idle();
        retire_stall = 1'b0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        settle();
        check_eq("rst_allowin", ws_allowin, 1);
        check_eq("rst_count", q_count, 0);
        check_eq("rst_instret", instret, 0);
        check_eq("rst_dbg_pc", debug_wb_pc, 0);
        check_eq("rst_wb_exc", wb_exc, 0);
        check_eq("rst_rf_we", rf_we, 0);
        check_eq("rst_csr_pending", csr_pending, 0);

        // Three back-to-back pushes, no stall
        drive(1'b1, 32'h1c000000, 1'b1, 5'd1, 32'h11, 1'b0, 14'h0, 1'b0, 6'h0);
        settle();
        check_eq("bb_allow0", ws_allowin, 1);
        check_eq("bb_rfwe0", rf_we, 0);
        tick();
        drive(1'b1, 32'h1c000004, 1'b1, 5'd2, 32'h22, 1'b0, 14'h0, 1'b0, 6'h0);
        settle();
        check_eq("bb_rfwe1", rf_we, 1);
        check_eq("bb_waddr1", rf_waddr, 1);
        check_eq("bb_wdata1", rf_wdata, 32'h11);
        check_eq("bb_dbgpc1", debug_wb_pc, 32'h1c000000);
        check_eq("bb_allow1", ws_allowin, 1);
        tick();
        drive(1'b1, 32'h1c000008, 1'b1, 5'd3, 32'h33, 1'b0, 14'h0, 1'b0, 6'h0);
        settle();
        check_eq("bb_waddr2", rf_waddr, 2);
        check_eq("bb_wdata2", rf_wdata, 32'h22);
        check_eq("bb_allow2", ws_allowin, 1);
        tick();
        idle();
        settle();
        check_eq("bb_waddr3", rf_waddr, 3);
        check_eq("bb_dbgwen3", debug_wb_rf_wen, 4'hf);
        tick();
        settle();
        check_eq("bb_rfwe_end", rf_we, 0);
        check_eq("bb_instret", instret, 3);
        check_eq("bb_count_end", q_count, 0);

        // Stall four cycles while pushing, then release
        retire_stall = 1'b1;
        drive(1'b1, 32'h100, 1'b1, 5'd4, 32'h44, 1'b0, 14'h0, 1'b0, 6'h0);
        settle();
        check_eq("st_allow0", ws_allowin, 1);
        tick();
        drive(1'b1, 32'h104, 1'b1, 5'd5, 32'h55, 1'b0, 14'h0, 1'b0, 6'h0);
        settle();
        check_eq("st_rfwe1", rf_we, 0);
        check_eq("st_dbgwen1", debug_wb_rf_wen, 0);
        check_eq("st_dbgpc1", debug_wb_pc, 32'h100);
        check_eq("st_count1", q_count, 1);
        tick();
        drive(1'b1, 32'h108, 1'b1, 5'd6, 32'h66, 1'b0, 14'h0, 1'b0, 6'h0);
        settle();
        check_eq("st_count2", q_count, 2);
        check_eq("st_allow2", ws_allowin, 0);
        check_eq("st_rfwe2", rf_we, 0);
        tick();
        settle();
        check_eq("st_count3", q_count, 2);
        check_eq("st_allow3", ws_allowin, 0);
        tick();
        retire_stall = 1'b0;
        idle();
        settle();
        check_eq("st_rel_rfwe0", rf_we, 1);
        check_eq("st_rel_waddr0", rf_waddr, 4);
        tick();
        settle();
        check_eq("st_rel_waddr1", rf_waddr, 5);
        check_eq("st_rel_wdata1", rf_wdata, 32'h55);
        tick();
        settle();
        check_eq("st_rfwe_end", rf_we, 0);
        check_eq("st_count_end", q_count, 0);
        check_eq("st_instret", instret, 5);

        // SYS|BRK at head, younger entry behind it
        retire_stall = 1'b1;
        drive(1'b1, 32'h1c000040, 1'b1, 5'd6, 32'h77, 1'b0, 14'h0, 1'b0, 6'b011000);
        tick();
        drive(1'b1, 32'h1c000044, 1'b1, 5'd7, 32'h88, 1'b0, 14'h0, 1'b0, 6'h0);
        tick();
        retire_stall = 1'b0;
        drive(1'b1, 32'h1c000048, 1'b1, 5'd8, 32'h99, 1'b0, 14'h0, 1'b0, 6'h0);
        settle();
        check_eq("sys_exc", wb_exc, 1);
        check_eq("sys_ecode", wb_ecode, 6'h0b);
        check_eq("sys_subcode", wb_esubcode, 0);
        check_eq("sys_pc", wb_pc, 32'h1c000040);
        check_eq("sys_rfwe", rf_we, 0);
        check_eq("sys_allow", ws_allowin, 0);
        tick();
        idle();
        settle();
        check_eq("sys_count_after", q_count, 0);
        check_eq("sys_exc_after", wb_exc, 0);
        check_eq("sys_instret", instret, 5);

        // ADEF|INT then ADEF alone; push in the flush cycle is dropped
        drive(1'b1, 32'h2000, 1'b1, 5'd9, 32'hAA, 1'b0, 14'h0, 1'b0, 6'b000011);
        tick();
        drive(1'b1, 32'h2004, 1'b1, 5'd9, 32'hBB, 1'b0, 14'h0, 1'b0, 6'h0);
        settle();
        check_eq("int_exc", wb_exc, 1);
        check_eq("int_ecode", wb_ecode, 6'h00);
        check_eq("int_subcode", wb_esubcode, 0);
        check_eq("int_allow", ws_allowin, 0);
        tick();
        drive(1'b1, 32'h2008, 1'b1, 5'd9, 32'hCC, 1'b0, 14'h0, 1'b0, 6'b000010);
        settle();
        check_eq("int_drop_count", q_count, 0);
        check_eq("int_drop_exc", wb_exc, 0);
        tick();
        drive(1'b1, 32'h200c, 1'b1, 5'd9, 32'hDD, 1'b0, 14'h0, 1'b0, 6'b100100);
        settle();
        check_eq("adef_exc", wb_exc, 1);
        check_eq("adef_ecode", wb_ecode, 6'h08);
        check_eq("adef_subcode", wb_esubcode, 9'h000);
        check_eq("adef_pc", wb_pc, 32'h2008);
        check_eq("adef_allow", ws_allowin, 0);
        tick();
        drive(1'b1, 32'h2010, 1'b1, 5'd9, 32'hEE, 1'b0, 14'h0, 1'b0, 6'b100100);
        tick();
        idle();
        settle();
        check_eq("ine_ecode", wb_ecode, 6'h0d);
        check_eq("ine_pc", wb_pc, 32'h2010);
        tick();
        settle();
        check_eq("exc_instret", instret, 5);
        check_eq("exc_quiet", wb_exc, 0);

        // ertn at head with a csr write behind it
        retire_stall = 1'b1;
        drive(1'b1, 32'h3000, 1'b0, 5'd0, 32'h0, 1'b0, 14'h0, 1'b1, 6'h0);
        settle();
        check_eq("ertn_pend0", csr_pending, 0);
        tick();
        drive(1'b1, 32'h3004, 1'b0, 5'd0, 32'h1234, 1'b1, 14'h006, 1'b0, 6'h0);
        settle();
        check_eq("ertn_pend1", csr_pending, 1);
        check_eq("ertn_pwnum1", csr_pending_wnum, 0);
        tick();
        retire_stall = 1'b0;
        idle();
        settle();
        check_eq("ertn_flush", ertn_flush, 1);
        check_eq("ertn_pend2", csr_pending, 1);
        check_eq("ertn_pwnum2", csr_pending_wnum, 14'h006);
        check_eq("ertn_csrwe", csr_we, 0);
        check_eq("ertn_noexc", wb_exc, 0);
        tick();
        settle();
        check_eq("ertn_flush_end", ertn_flush, 0);
        check_eq("ertn_csrwe_end", csr_we, 0);
        check_eq("ertn_count_end", q_count, 0);
        check_eq("ertn_pend_end", csr_pending, 0);
        check_eq("ertn_instret", instret, 6);

        // Plain CSR write commit
        drive(1'b1, 32'h3008, 1'b0, 5'd0, 32'h5678, 1'b1, 14'h00c, 1'b0, 6'h0);
        tick();
        idle();
        settle();
        check_eq("csr_we", csr_we, 1);
        check_eq("csr_wnum", csr_wnum, 14'h00c);
        check_eq("csr_wval", csr_wval, 32'h5678);
        check_eq("csr_wmask", csr_wmask, 32'hffffa987);
        tick();
        settle();
        check_eq("csr_instret", instret, 7);

        // Reset with two entries queued
        retire_stall = 1'b1;
        drive(1'b1, 32'h4000, 1'b1, 5'd1, 32'h1, 1'b0, 14'h0, 1'b0, 6'b001000);
        tick();
        drive(1'b1, 32'h4004, 1'b0, 5'd0, 32'h0, 1'b0, 14'h0, 1'b1, 6'h0);
        tick();
        idle();
        settle();
        check_eq("mrst_count_pre", q_count, 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        retire_stall = 1'b0;
        settle();
        check_eq("mrst_count", q_count, 0);
        check_eq("mrst_allow", ws_allowin, 1);
        check_eq("mrst_exc", wb_exc, 0);
        check_eq("mrst_ertn", ertn_flush, 0);
        check_eq("mrst_instret", instret, 0);
        tick();
        settle();
        check_eq("mrst_exc_next", wb_exc, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
